// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
//
// Load/store bus between the MEM stage (master) and the data-memory
// responder (slave). Two independent valid/ready handshakes: one carries the
// request, the other carries the response.
//
// Signals:
//   req_valid  master->slave  request present
//   req_ready  slave->master  responder can accept a request
//   req_we     master->slave  1 = store, 0 = load
//   req_addr   master->slave  byte address (32 bits)
//   req_wdata  master->slave  store data (32 bits)
//   req_be     master->slave  byte enables, bit k covers bits 8k+7:8k
//   rsp_valid  slave->master  response present
//   rsp_ready  master->slave  requester accepts the response
//   rsp_rdata  slave->master  load data, 0 for stores and errored requests
//   rsp_err    slave->master  request was misaligned or out of range
//   busy       slave->master  a request is in flight
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory target for the MEM stage of the pipeline. Accepts one word
// request at a time, waits LATENCY cycles, performs the load or byte-enabled
// store on a local 2^ADDR_W x 32 array, then presents a single response and
// holds it until the requester takes it.
//
// Parameters:
//   ADDR_W   word-address bits (array depth 2^ADDR_W), must be < 30
//   LATENCY  cycles from request acceptance to array access, legal 1..15
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (control and response registers only;
//        the array keeps its contents)
//   bus  dmem_responder_if.slave - request/response handshakes and busy flag
//
// Build option:
//   DMEM_RESP_ERR_EN  when defined, misaligned addresses or addresses with
//                     bits set above the array range get rsp_err = 1, read
//                     data 0 and no array write. When undefined rsp_err is 0
//                     and those address bits are ignored (addresses alias).
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [3:0] cnt;
    logic [3:0] cnt_nx;

    logic accept;
    logic access;
    logic mem_we;

    // Request fields captured at the acceptance edge.
    logic              we_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              err_q;

    // Response registers, held stable throughout RESP.
    logic [31:0] rdata_r;
    logic        err_r;

    logic [31:0] mem [DEPTH];

    logic req_addr_err;

`ifdef DMEM_RESP_ERR_EN
    assign req_addr_err = (bus.req_addr[1:0] != 2'b00) ||
                          (|bus.req_addr[31:ADDR_W+2]);
`else
    // Byte offset and high bits do not take part in decoding; addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};
    assign req_addr_err     = 1'b0;
`endif

    // ---- next-state / control decode ----------------------------------------
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        access   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept   = 1'b1;
                    cnt_nx   = CNT_INIT;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    access   = 1'b1;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // A store whose access edge coincides with reset is discarded.
    assign mem_we = access && we_q && !err_q && !rst;

    // ---- state, counter and response registers ------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (access) begin
                rdata_r <= (we_q || err_q) ? 32'd0 : mem[idx_q];
                err_r   <= err_q;
            end
        end
    end

    // ---- request capture (data path, no reset) ------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            idx_q   <= bus.req_addr[ADDR_W+1:2];
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            err_q   <= req_addr_err;
        end
    end

    // ---- word array, one write port with per-lane enables -------------------
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_we && be_q[k]) begin
                mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
            end
        end
    end

    // Handshake outputs are decoded from the registered state only.
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_rdata = rdata_r;
    assign bus.rsp_err   = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Bench for dmem_responder. u_dut (LATENCY=2) carries the directed table and
// the randomized traffic; u_dut3 (LATENCY=3) carries the reset-mid-store
// sequence. A word-array model computed from address arithmetic supplies the
// expected responses for random traffic. Honors DMEM_RESP_ERR_EN the same way
// the design does.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int LAT   = 2;
    localparam int LAT3  = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    dmem_responder #(.ADDR_W(AW), .LATENCY(LAT3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---- reference model -----------------------------------------------------
    logic [31:0] ref_mem [DEPTH];

    function automatic void model(input bit we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  output logic [31:0] rd, output bit err);
        int unsigned idx;
        idx = (addr / 4) % DEPTH;
`ifdef DMEM_RESP_ERR_EN
        err = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
`else
        err = 1'b0;
`endif
        rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) ref_mem[idx][8*k +: 8] = wdata[8*k +: 8];
                end
            end else begin
                rd = ref_mem[idx];
            end
        end
    endfunction

    // ---- one transaction on u_dut, with optional response backpressure -------
    task automatic txn0(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic er);
        int k;
        rd = 32'd0;
        er = 1'b0;
        @(negedge clk);
        bus0.req_valid = 1'b1;
        bus0.req_we    = we;
        bus0.req_addr  = addr;
        bus0.req_wdata = wdata;
        bus0.req_be    = be;
        bus0.rsp_ready = 1'b0;
        check("req_ready_idle", 32'(bus0.req_ready), 32'd1);
        @(negedge clk);
        // Fields change right after acceptance; the response must not care.
        bus0.req_valid = 1'b0;
        bus0.req_we    = 1'($urandom);
        bus0.req_addr  = $urandom;
        bus0.req_wdata = $urandom;
        bus0.req_be    = 4'($urandom);
        check("req_ready_after_accept", 32'(bus0.req_ready), 32'd0);
        check("busy_after_accept", 32'(bus0.busy), 32'd1);
        k = 0;
        while (!bus0.rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("rsp_latency", 32'(k), 32'(LAT));
        if (!bus0.rsp_valid) return;
        rd = bus0.rsp_rdata;
        er = bus0.rsp_err;
        for (int h = 0; h < hold; h++) begin
            bus0.req_valid = 1'b1;
            @(negedge clk);
            check("hold_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
            check("hold_rsp_rdata", bus0.rsp_rdata, rd);
            check("hold_req_ready", 32'(bus0.req_ready), 32'd0);
        end
        bus0.req_valid = 1'b0;
        bus0.rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_valid_after_hs", 32'(bus0.rsp_valid), 32'd0);
        check("req_ready_after_hs", 32'(bus0.req_ready), 32'd1);
        bus0.rsp_ready = 1'b0;
    endtask

    // ---- one transaction on u_dut3, response taken immediately ----------------
    task automatic txn1(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd);
        int k;
        rd = 32'd0;
        @(negedge clk);
        bus1.req_valid = 1'b1;
        bus1.req_we    = we;
        bus1.req_addr  = addr;
        bus1.req_wdata = wdata;
        bus1.req_be    = be;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        k = 0;
        while (!bus1.rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("rsp_latency3", 32'(k), 32'(LAT3));
        if (!bus1.rsp_valid) return;
        rd = bus1.rsp_rdata;
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        bus1.rsp_ready = 1'b0;
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] m_rd;
        bit          m_err;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;

        rst = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
        bus0.req_wdata = '0;   bus0.req_be = '0;   bus0.rsp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
        bus1.req_wdata = '0;   bus1.req_be = '0;   bus1.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus0.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus0.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus0.rsp_err), 32'd0);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst3_req_ready", 32'(bus1.req_ready), 32'd1);
        check("rst3_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        rst = 1'b0;

        // ---- directed table ----------------------------------------------------
        tbl.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h10, 32'h0,        4'h0, 5, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h10, 32'h000000AA, 4'h1, 0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h10, 32'h0,        4'hF, 0, 32'hDEADBEAA, 1'b0});
        tbl.push_back('{1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h10, 32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0});
        tbl.push_back('{1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h20, 32'h11223344, 4'hA, 0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h20, 32'h0,        4'h0, 2, 32'h11FE330D, 1'b0});
`ifdef DMEM_RESP_ERR_EN
        tbl.push_back('{1'b1, 32'h12,  32'h55667788, 4'hF, 0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h400, 32'h0,        4'h0, 0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0});
`else
        tbl.push_back('{1'b1, 32'h412, 32'h55667788, 4'hF, 0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 0, 32'h55667788, 1'b0});
`endif
        foreach (tbl[i]) begin
            model(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, m_rd, m_err);
            txn0(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].hold, rd, er);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
        end

        // ---- randomized traffic against the model --------------------------------
        for (int i = 0; i < 16; i++) begin
            wdata = $urandom;
            model(1'b1, 32'(i * 4), wdata, 4'hF, m_rd, m_err);
            txn0(1'b1, 32'(i * 4), wdata, 4'hF, 0, rd, er);
            check("init_rdata", rd, m_rd);
        end
        for (int i = 0; i < 48; i++) begin
            we    = 1'($urandom);
            addr  = 32'($urandom_range(0, 15)) * 4;
            case ($urandom_range(0, 7))
                0:       addr = addr | 32'($urandom_range(1, 3));
                1:       addr = addr | (32'($urandom_range(1, 4)) << 10);
                default: ;
            endcase
            wdata = $urandom;
            be    = 4'($urandom);
            model(we, addr, wdata, be, m_rd, m_err);
            txn0(we, addr, wdata, be, $urandom_range(0, 2), rd, er);
            check($sformatf("rnd%0d_rdata a=%08h", i, addr), rd, m_rd);
            check($sformatf("rnd%0d_err a=%08h", i, addr), 32'(er), 32'(m_err));
        end

        // ---- reset in the middle of a store (LATENCY=3) --------------------------
        txn1(1'b1, 32'h30, 32'h12345678, 4'hF, rd);
        check("mid_rst_prestore_rdata", rd, 32'd0);
        @(negedge clk);
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b1;
        bus1.req_addr  = 32'h30;
        bus1.req_wdata = 32'hFFFF0000;
        bus1.req_be    = 4'hF;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        check("mid_rst_busy_before", 32'(bus1.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_req_ready", 32'(bus1.req_ready), 32'd1);
        check("mid_rst_busy", 32'(bus1.busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("mid_rst_no_rsp", 32'(bus1.rsp_valid), 32'd0);
            @(negedge clk);
        end
        txn1(1'b0, 32'h30, 32'h0, 4'h0, rd);
        check("mid_rst_old_contents", rd, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
